alu_control_muldiv: RTL and testbench
=====================================

Name: alu_control_muldiv

Overview:
- Parametrised successor to the EX-stage ALU control decoder. Decodes alu_op/funct to the 4-bit ALU operation code.
- Adds an iterative signed multiply/divide sequencer that owns the HI/LO registers.
- Drives a stall to the hazard unit while a mult/div is in flight.
- Sits in EX, beside the main ALU. mfhi/mflo read hi/lo from this block.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width (even, >=8)
- ALUOP_WIDTH, 2, width of alu_op from main control
- CTRL_WIDTH, 4, width of the ALU operation code

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- alu_op  in  ALUOP_WIDTH  0=add, 1=sub, 2=R-type (use funct), other=unknown
- funct  in  6  R-type function field
- issue  in  1  EX instruction valid this cycle
- rs_val  in  DATA_WIDTH  dividend / multiplicand
- rt_val  in  DATA_WIDTH  divisor / multiplier
- alu_ctrl  out  CTRL_WIDTH  ALU operation code
- stall  out  1  hold IF/ID/EX this cycle
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse after HI/LO written
- hi  out  DATA_WIDTH  HI register
- lo  out  DATA_WIDTH  LO register
- div_by_zero  out  1  last div had rt_val==0

Behaviour:
- Decode codes:
  - alu_op=0 -> 2; alu_op=1 -> 6.
  - alu_op=2 with funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2a->7, 0x27->C, 0x10(mfhi)->3, 0x12(mflo)->4, 0x18(mult)->5, 0x1a(div)->8.
- Unknown alu_op or funct: alu_ctrl outputs a registered last_ctrl, which is the code of the last issued decodable op. last_ctrl updates on any edge with issue=1 and a valid decode.
- alu_ctrl is combinational from the inputs when the decode is valid.
- Reset (async, rst=1): last_ctrl=2, alu_ctrl=2 (when the decode is unknown), FSM=IDLE, hi=lo=0, busy=0, done=0, div_by_zero=0, count=0. Reset mid-operation aborts the op and discards partial results.
- FSM states:
  - IDLE: issue && mult/div decoded && !rst -> latch |rs|, |rt| and the result sign bits; load count=DATA_WIDTH; go to MUL or DIV.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring shift-subtract, one bit per cycle.
  - MUL/DIV: count decrements each edge. On the edge where count==1, write the sign-corrected result to hi/lo and return to IDLE.
- Latency: start sampled at edge k. busy=1 from after edge k through edge k+DATA_WIDTH. hi/lo written at edge k+DATA_WIDTH. done=1 for exactly the following cycle.
- Counter width is $clog2(DATA_WIDTH)+1.
- mult result: signed 2W-bit product; hi = upper half, lo = lower half.
- div result: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - MIN/-1 gives lo=MIN, hi=0.
- rt_val==0 on div: lo=all-ones, hi=rs_val (no sign fix); div_by_zero set at the write edge. div_by_zero is cleared on the next div start; mult leaves it unchanged.
- stall = busy && issue && decode in {mfhi, mflo, mult, div}. Combinational, no registered delay.
  - A stalled mult/div starts on the edge after busy falls, i.e. the first IDLE cycle.
  - Other ops never stall.
- hi/lo hold their values while busy. mfhi/mflo reads in IDLE return the current hi/lo.

Optional Feature:
- Macro: MULDIV_UNSIGNED_EN.
- Defined: funct 0x19 (multu) -> code 9, and 0x1b (divu) -> code A. These use unsigned operands with no sign fix, stall and hazard-interlock like mult/div, and divu by zero gives lo=all-ones, hi=rs_val.
- Undefined: 0x19 and 0x1b are unknown functs. alu_ctrl holds last_ctrl and no sequencer start occurs.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU code localparams (ALU_ADD=2 ... ALU_NOR=C, ALU_MULTU=9, ALU_DIVU=A)
  - funct constants
  - FSM state typedef {IDLE, MUL, DIV}
- Sub-module muldiv_iter: the iterative shift/add-subtract datapath plus count, with start/op/signed in and result/last out.
- Top level: decode, last_ctrl, stall, and sign handling.

Test Plan:
- Reset: assert rst mid-cycle with no clock -> alu_ctrl=2, hi=lo=0, busy=0, done=0 immediately.
- Decode:
  - alu_op=2 funct=0x25 issue -> 1.
  - Then funct=0x3f -> alu_ctrl stays 1.
  - alu_op=1 -> 6; alu_op=3 -> 6 held.
- mult: rs=0xFFFFFFFD, rt=7 -> busy for 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, and done pulses once.
- div:
  - rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- Interlock:
  - During a mult, issue mflo -> stall=1 every cycle until busy=0, then lo is valid.
  - Issue add during busy -> stall=0, alu_ctrl=2.
- Reset mid-op: start div; at cycle 10 pulse rst -> FSM IDLE, hi=lo=0, no done pulse.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the EX-stage ALU control decoder and its
// multiply/divide sequencer: ALU operation codes, R-type funct values
// and the sequencer state type.
package alu_ctrl_pkg;

    // ALU operation codes driven on alu_ctrl
    localparam logic [3:0] ALU_AND   = 4'h0;
    localparam logic [3:0] ALU_OR    = 4'h1;
    localparam logic [3:0] ALU_ADD   = 4'h2;
    localparam logic [3:0] ALU_MFHI  = 4'h3;
    localparam logic [3:0] ALU_MFLO  = 4'h4;
    localparam logic [3:0] ALU_MULT  = 4'h5;
    localparam logic [3:0] ALU_SUB   = 4'h6;
    localparam logic [3:0] ALU_SLT   = 4'h7;
    localparam logic [3:0] ALU_DIV   = 4'h8;
    localparam logic [3:0] ALU_MULTU = 4'h9;
    localparam logic [3:0] ALU_DIVU  = 4'hA;
    localparam logic [3:0] ALU_NOR   = 4'hC;

    // R-type funct field values
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    // Sequencer state
    typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

endpackage

// File: rtl/alu_control_muldiv_iter.sv
// muldiv_iter
// Iterative unsigned shift-add multiplier / restoring divider, one bit per
// cycle. Operates on magnitudes only; sign handling lives in the parent.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, op_div   begin an operation (op_div=1 divide, 0 multiply)
//   a, b            multiplicand/multiplier or dividend/divisor magnitudes
//   state           sequencer state (also serves as a debug view)
//   busy            state != IDLE
//   last            final iteration; res_hi/res_lo hold the finished result
//   res_hi, res_lo  next-iteration accumulator (product hi/lo or rem/quot)
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output md_state_t             state,
    output logic                  busy,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    // acc_hi: partial product high half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting into quotient
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [W-1:0]  opnd;
    logic [CW-1:0] count;
    logic [W:0]    mul_sum;
    logic [W:0]    div_shift;
    logic [W:0]    div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[W-1]};
        // Bit W set means the trial subtract borrowed, so no quotient bit
        div_diff  = div_shift - {1'b0, opnd};
        res_hi    = acc_hi;
        res_lo    = acc_lo;
        if (state == MUL) begin
            res_hi = mul_sum[W:1];
            res_lo = {mul_sum[0], acc_lo[W-1:1]};
        end else if (state == DIV) begin
            if (div_diff[W]) begin
                res_hi = div_shift[W-1:0];
                res_lo = {acc_lo[W-2:0], 1'b0};
            end else begin
                res_hi = div_diff[W-1:0];
                res_lo = {acc_lo[W-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= op_div ? DIV : MUL;
                        count  <= CW'(W);
                        opnd   <= op_div ? b : a;
                        acc_hi <= '0;
                        acc_lo <= op_div ? a : b;
                    end
                end
                default: begin
                    acc_hi <= res_hi;
                    acc_lo <= res_lo;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign last = busy && (count == CW'(1));

endmodule

// File: rtl/alu_control_muldiv.sv
// alu_control_muldiv
// EX-stage ALU control decoder with an iterative multiply/divide sequencer
// that owns HI/LO and interlocks dependent instructions via stall.
// Optional macro MULDIV_UNSIGNED_EN adds multu (code 9) and divu (code A).
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   alu_op, funct    main-control op class and R-type funct field
//   issue            EX instruction valid this cycle
//   rs_val, rt_val   dividend/multiplicand, divisor/multiplier
//   alu_ctrl         ALU operation code (last valid code when undecodable)
//   stall            hold IF/ID/EX: HI/LO user issued while sequencer busy
//   busy             sequencer active
//   done             one-cycle pulse after HI/LO written
//   hi, lo           HI/LO registers
//   div_by_zero      last divide had a zero divisor
module alu_control_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 2,
    parameter int CTRL_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ALUOP_WIDTH-1:0] alu_op,
    input  logic [5:0]             funct,
    input  logic                   issue,
    input  logic [DATA_WIDTH-1:0]  rs_val,
    input  logic [DATA_WIDTH-1:0]  rt_val,
    output logic [CTRL_WIDTH-1:0]  alu_ctrl,
    output logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  hi,
    output logic [DATA_WIDTH-1:0]  lo,
    output logic                   div_by_zero
);
    localparam int W = DATA_WIDTH;

    logic [CTRL_WIDTH-1:0] dec_code;
    logic [CTRL_WIDTH-1:0] last_ctrl;
    logic                  dec_valid;
    logic                  dec_hilo;
    logic                  dec_md;
    logic                  dec_div;
    logic                  dec_signed;

    always_comb begin
        dec_valid  = 1'b1;
        dec_code   = CTRL_WIDTH'(ALU_ADD);
        dec_hilo   = 1'b0;
        dec_md     = 1'b0;
        dec_div    = 1'b0;
        dec_signed = 1'b1;
        if (alu_op == ALUOP_WIDTH'(0)) begin
            dec_code = CTRL_WIDTH'(ALU_ADD);
        end else if (alu_op == ALUOP_WIDTH'(1)) begin
            dec_code = CTRL_WIDTH'(ALU_SUB);
        end else if (alu_op == ALUOP_WIDTH'(2)) begin
            case (funct)
                FN_ADD:  dec_code = CTRL_WIDTH'(ALU_ADD);
                FN_SUB:  dec_code = CTRL_WIDTH'(ALU_SUB);
                FN_AND:  dec_code = CTRL_WIDTH'(ALU_AND);
                FN_OR:   dec_code = CTRL_WIDTH'(ALU_OR);
                FN_SLT:  dec_code = CTRL_WIDTH'(ALU_SLT);
                FN_NOR:  dec_code = CTRL_WIDTH'(ALU_NOR);
                FN_MFHI: begin dec_code = CTRL_WIDTH'(ALU_MFHI); dec_hilo = 1'b1; end
                FN_MFLO: begin dec_code = CTRL_WIDTH'(ALU_MFLO); dec_hilo = 1'b1; end
                FN_MULT: begin dec_code = CTRL_WIDTH'(ALU_MULT); dec_md = 1'b1; end
                FN_DIV:  begin dec_code = CTRL_WIDTH'(ALU_DIV); dec_md = 1'b1; dec_div = 1'b1; end
`ifdef MULDIV_UNSIGNED_EN
                FN_MULTU: begin
                    dec_code = CTRL_WIDTH'(ALU_MULTU); dec_md = 1'b1; dec_signed = 1'b0;
                end
                FN_DIVU: begin
                    dec_code = CTRL_WIDTH'(ALU_DIVU); dec_md = 1'b1; dec_div = 1'b1;
                    dec_signed = 1'b0;
                end
`endif
                default: dec_valid = 1'b0;
            endcase
        end else begin
            dec_valid = 1'b0;
        end
    end

    assign alu_ctrl = dec_valid ? dec_code : last_ctrl;

    // A mult/div issued while busy is held by stall and starts on the first
    // IDLE cycle, so start only needs to look at busy.
    logic start;
    assign start = issue && dec_md && !busy;
    assign stall = busy && issue && (dec_hilo || dec_md);

    // Magnitudes fed to the unsigned datapath; |MIN| wraps to 2^(W-1) which
    // is still the correct unsigned magnitude.
    logic         rs_neg;
    logic         rt_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    assign rs_neg = dec_signed & rs_val[W-1];
    assign rt_neg = dec_signed & rt_val[W-1];
    assign a_mag  = rs_neg ? -rs_val : rs_val;
    assign b_mag  = rt_neg ? -rt_val : rt_val;

    md_state_t    md_state;
    logic         last;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;

    muldiv_iter #(.DATA_WIDTH(W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_div (dec_div),
        .a      (a_mag),
        .b      (b_mag),
        .state  (md_state),
        .busy   (busy),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Sign context captured at start: sgn_q for product/quotient,
    // sgn_r for remainder (follows dividend).
    logic         sgn_q;
    logic         sgn_r;
    logic         dz_q;
    logic [W-1:0] rs_q;
    logic [W-1:0] fix_hi;
    logic [W-1:0] fix_lo;
    logic [2*W-1:0] prod;

    always_comb begin
        prod   = sgn_q ? -{res_hi, res_lo} : {res_hi, res_lo};
        fix_hi = prod[2*W-1:W];
        fix_lo = prod[W-1:0];
        if (md_state == DIV) begin
            if (dz_q) begin
                fix_hi = rs_q;
                fix_lo = '1;
            end else begin
                fix_hi = sgn_r ? -res_hi : res_hi;
                fix_lo = sgn_q ? -res_lo : res_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ctrl   <= CTRL_WIDTH'(ALU_ADD);
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            sgn_q       <= 1'b0;
            sgn_r       <= 1'b0;
            dz_q        <= 1'b0;
            rs_q        <= '0;
        end else begin
            done <= last;
            if (issue && dec_valid) begin
                last_ctrl <= dec_code;
            end
            if (start) begin
                sgn_q <= rs_neg ^ rt_neg;
                sgn_r <= rs_neg;
                dz_q  <= dec_div && (rt_val == '0);
                rs_q  <= rs_val;
                if (dec_div) begin
                    div_by_zero <= 1'b0;
                end
            end
            if (last) begin
                hi <= fix_hi;
                lo <= fix_lo;
                if (md_state == DIV) begin
                    div_by_zero <= dz_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
module tb_alu_control_muldiv;
    import alu_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        issue;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  alu_ctrl;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks = 0;
    int failures = 0;

    // Expected HI/LO from the last completed operation (bench-side model)
    logic [31:0] exp_hi_prev = '0;
    logic [31:0] exp_lo_prev = '0;

`ifdef MULDIV_UNSIGNED_EN
    localparam logic [3:0] EXP_19 = 4'h9;
    localparam logic [3:0] EXP_1B = 4'hA;
`else
    localparam logic [3:0] EXP_19 = 4'h4;
    localparam logic [3:0] EXP_1B = 4'h4;
`endif

    typedef struct {
        logic [1:0] op;
        logic [5:0] fn;
        logic       iss;
        logic [3:0] exp;
    } dec_vec_t;

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  code;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
    } md_vec_t;

    dec_vec_t dvec[$];
    md_vec_t  mvec[$];

    alu_control_muldiv #(.DATA_WIDTH(32), .ALUOP_WIDTH(2), .CTRL_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_op      (alu_op),
        .funct       (funct),
        .issue       (issue),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .alu_ctrl    (alu_ctrl),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one mult/div, follow it to completion, check latency and results
    task automatic run_md(input md_vec_t v);
        int n;
        int done_bad;
        int hold_bad;
        alu_op = 2'd2;
        funct  = v.fn;
        rs_val = v.rs;
        rt_val = v.rt;
        issue  = 1'b1;
        #1;
        check("md_code", alu_ctrl, v.code);
        check("md_no_stall_idle", stall, 1'b0);
        tick();
        issue = 1'b0;
        n = 0;
        done_bad = 0;
        hold_bad = 0;
        while (busy && n < 100) begin
            if (done) done_bad++;
            if (hi !== exp_hi_prev || lo !== exp_lo_prev) hold_bad++;
            tick();
            n++;
        end
        check("md_latency", n, 32);
        check("md_no_early_done", done_bad, 0);
        check("md_hilo_hold", hold_bad, 0);
        check("md_done_pulse", done, 1'b1);
        check("md_hi", hi, v.ehi);
        check("md_lo", lo, v.elo);
        check("md_dbz", div_by_zero, v.edbz);
        exp_hi_prev = v.ehi;
        exp_lo_prev = v.elo;
        tick();
        check("md_done_once", done, 1'b0);
    endtask

    initial begin
        int n;
        int bad;

        // Decode table: sequence matters because unknown entries hold last_ctrl
        dvec.push_back('{2'd2, 6'h25, 1'b1, 4'h1});
        dvec.push_back('{2'd2, 6'h3f, 1'b1, 4'h1});
        dvec.push_back('{2'd1, 6'h00, 1'b1, 4'h6});
        dvec.push_back('{2'd3, 6'h00, 1'b1, 4'h6});
        dvec.push_back('{2'd0, 6'h00, 1'b1, 4'h2});
        dvec.push_back('{2'd2, 6'h20, 1'b1, 4'h2});
        dvec.push_back('{2'd2, 6'h22, 1'b1, 4'h6});
        dvec.push_back('{2'd2, 6'h24, 1'b1, 4'h0});
        dvec.push_back('{2'd2, 6'h2a, 1'b1, 4'h7});
        dvec.push_back('{2'd2, 6'h27, 1'b1, 4'hC});
        dvec.push_back('{2'd3, 6'h00, 1'b1, 4'hC});
        dvec.push_back('{2'd2, 6'h10, 1'b0, 4'h3});
        dvec.push_back('{2'd3, 6'h00, 1'b0, 4'hC});
        dvec.push_back('{2'd2, 6'h12, 1'b1, 4'h4});
        dvec.push_back('{2'd2, 6'h00, 1'b1, 4'h4});
        dvec.push_back('{2'd2, 6'h19, 1'b0, EXP_19});
        dvec.push_back('{2'd2, 6'h1b, 1'b0, EXP_1B});
        dvec.push_back('{2'd2, 6'h18, 1'b0, 4'h5});
        dvec.push_back('{2'd2, 6'h1a, 1'b0, 4'h8});
        dvec.push_back('{2'd3, 6'h00, 1'b0, 4'h4});
        dvec.push_back('{2'd2, 6'h3f, 1'b1, 4'h4});

        // Multiply/divide table with hand-computed results
        mvec.push_back('{6'h18, 32'hFFFFFFFD, 32'd7,        4'h5, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0});
        mvec.push_back('{6'h1a, 32'hFFFFFFF9, 32'd2,        4'h8, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
        mvec.push_back('{6'h1a, 32'd5,        32'd0,        4'h8, 32'd5,        32'hFFFFFFFF, 1'b1});
        mvec.push_back('{6'h18, 32'd2,        32'd3,        4'h5, 32'd0,        32'd6,        1'b1});
        mvec.push_back('{6'h1a, 32'd100,      32'hFFFFFFF9, 4'h8, 32'd2,        32'hFFFFFFF2, 1'b0});
        mvec.push_back('{6'h1a, 32'hFFFFFF9C, 32'hFFFFFFF9, 4'h8, 32'hFFFFFFFE, 32'd14,       1'b0});
        mvec.push_back('{6'h1a, 32'h80000000, 32'hFFFFFFFF, 4'h8, 32'd0,        32'h80000000, 1'b0});
        mvec.push_back('{6'h18, 32'h80000000, 32'h80000000, 4'h5, 32'h40000000, 32'd0,        1'b0});
        mvec.push_back('{6'h18, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h5, 32'd0,        32'd1,        1'b0});

        // Asynchronous reset with no clock edge yet
        rst    = 1'b0;
        alu_op = 2'd3;
        funct  = 6'h00;
        issue  = 1'b0;
        rs_val = '0;
        rt_val = '0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_alu_ctrl", alu_ctrl, 4'h2);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dbz", div_by_zero, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Decode vectors
        for (int i = 0; i < dvec.size(); i++) begin
            alu_op = dvec[i].op;
            funct  = dvec[i].fn;
            issue  = dvec[i].iss;
            #1;
            check($sformatf("dec_%0d", i), alu_ctrl, dvec[i].exp);
            check($sformatf("dec_busy_%0d", i), busy, 1'b0);
            tick();
        end
        issue = 1'b0;

        // Multiply/divide vectors
        for (int i = 0; i < mvec.size(); i++) begin
            run_md(mvec[i]);
        end
`ifdef MULDIV_UNSIGNED_EN
        run_md('{6'h19, 32'hFFFFFFFF, 32'd2, 4'h9, 32'd1, 32'hFFFFFFFE, 1'b0});
        run_md('{6'h1b, 32'hFFFFFFFF, 32'd2, 4'hA, 32'd1, 32'h7FFFFFFF, 1'b0});
        run_md('{6'h1b, 32'hFFFFFFF0, 32'd0, 4'hA, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1});
`endif

        // Interlock: mflo during a mult stalls, an add mid-way does not
        alu_op = 2'd2;
        funct  = 6'h18;
        rs_val = 32'd5;
        rt_val = 32'd6;
        issue  = 1'b1;
        #1;
        tick();
        n = 0;
        bad = 0;
        while (busy && n < 100) begin
            if (n == 10) begin
                alu_op = 2'd0;
                #1;
                check("il_add_no_stall", stall, 1'b0);
                check("il_add_code", alu_ctrl, 4'h2);
            end else begin
                alu_op = 2'd2;
                funct  = 6'h12;
                #1;
                if (stall !== 1'b1) bad++;
            end
            tick();
            n++;
        end
        check("il_latency", n, 32);
        check("il_mflo_stalled", bad, 0);
        alu_op = 2'd2;
        funct  = 6'h12;
        #1;
        check("il_release_stall", stall, 1'b0);
        check("il_mflo_code", alu_ctrl, 4'h4);
        check("il_lo", lo, 32'd30);
        check("il_hi", hi, 32'd0);
        tick();
        issue = 1'b0;
        exp_hi_prev = 32'd0;
        exp_lo_prev = 32'd30;

        // Stalled mult waits for the div in flight, then starts on the first IDLE edge
        alu_op = 2'd2;
        funct  = 6'h1a;
        rs_val = 32'd100;
        rt_val = 32'd7;
        issue  = 1'b1;
        #1;
        tick();
        funct  = 6'h18;
        rs_val = 32'hFFFFFFFF;
        rt_val = 32'd9;
        n = 0;
        bad = 0;
        while (busy && n < 100) begin
            if (stall !== 1'b1) bad++;
            tick();
            n++;
        end
        check("ss_div_latency", n, 32);
        check("ss_stalled", bad, 0);
        check("ss_release_stall", stall, 1'b0);
        check("ss_div_done", done, 1'b1);
        check("ss_div_hi", hi, 32'd2);
        check("ss_div_lo", lo, 32'd14);
        tick();
        issue = 1'b0;
        check("ss_mult_started", busy, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("ss_mult_latency", n, 32);
        check("ss_mult_hi", hi, 32'hFFFFFFFF);
        check("ss_mult_lo", lo, 32'hFFFFFFF7);
        check("ss_dbz", div_by_zero, 1'b0);
        tick();

        // Reset mid-operation aborts the divide
        alu_op = 2'd2;
        funct  = 6'h1a;
        rs_val = 32'd100;
        rt_val = 32'd7;
        issue  = 1'b1;
        #1;
        tick();
        issue = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mr_busy_before", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("mr_busy", busy, 1'b0);
        check("mr_hi", hi, 32'd0);
        check("mr_lo", lo, 32'd0);
        check("mr_done", done, 1'b0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        check("mr_no_done", bad, 0);
        alu_op = 2'd3;
        #1;
        check("mr_alu_ctrl", alu_ctrl, 4'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
